// File: rtl/seq_divider.sv
// Sequential signed restoring divider: N_WIDTH dividend / D_WIDTH divisor, one quotient bit per clock.
// Optional build macro SEQ_DIVIDER_DBZ_FLAG_EN adds a registered divide-by-zero flag output (dbz).
module seq_divider #(
  parameter int N_WIDTH = 16,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_WIDTH-1:0] Dividend,
  input  logic [D_WIDTH-1:0] Divisor,
  output logic [N_WIDTH-1:0] Quotient,
  output logic [D_WIDTH-1:0] Remainder,
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
  output logic               ready,
  output logic               dbz
`else
  output logic               ready
`endif
);

  localparam int CW = $clog2(N_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg;
  logic [D_WIDTH:0]   rem_reg;
  logic [N_WIDTH-1:0] quo_reg;
  logic [D_WIDTH-1:0] dvs_reg;
  logic               sign_n_reg, sign_d_reg, dz_reg;

  logic [N_WIDTH-1:0] abs_n, q_neg;
  logic [D_WIDTH-1:0] abs_d, r_neg;
  logic [D_WIDTH+1:0] rem_sh, trial;

  // Magnitudes are unsigned, so the most-negative operands map to 2^(width-1).
  assign abs_n  = Dividend[N_WIDTH-1] ? -Dividend : Dividend;
  assign abs_d  = Divisor[D_WIDTH-1]  ? -Divisor  : Divisor;
  assign rem_sh = {rem_reg, quo_reg[N_WIDTH-1]};
  assign trial  = rem_sh - {2'b00, dvs_reg};
  assign q_neg  = -quo_reg;
  assign r_neg  = -rem_reg[D_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = DIV;
      DIV:     if (cnt_reg == CW'(1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg    <= '0;
      rem_reg    <= '0;
      quo_reg    <= '0;
      dvs_reg    <= '0;
      sign_n_reg <= 1'b0;
      sign_d_reg <= 1'b0;
      dz_reg     <= 1'b0;
      Quotient   <= '0;
      Remainder  <= '0;
      ready      <= 1'b0;
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
      dbz        <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          quo_reg    <= abs_n;
          dvs_reg    <= abs_d;
          sign_n_reg <= Dividend[N_WIDTH-1];
          sign_d_reg <= Divisor[D_WIDTH-1];
          dz_reg     <= (Divisor == '0);
          rem_reg    <= '0;
          cnt_reg    <= CW'(N_WIDTH);
          ready      <= 1'b0;
        end
        DIV: begin
          // trial's top bit is the borrow: set means the subtraction went negative, so restore.
          if (!trial[D_WIDTH+1]) begin
            rem_reg <= trial[D_WIDTH:0];
            quo_reg <= {quo_reg[N_WIDTH-2:0], 1'b1};
          end else begin
            rem_reg <= rem_sh[D_WIDTH:0];
            quo_reg <= {quo_reg[N_WIDTH-2:0], 1'b0};
          end
          cnt_reg <= cnt_reg - CW'(1);
        end
        FIX: begin
          if (dz_reg) begin
            Quotient  <= sign_n_reg ? {1'b1, {(N_WIDTH-1){1'b0}}} : {1'b0, {(N_WIDTH-1){1'b1}}};
            Remainder <= '0;
          end else begin
            Quotient  <= (sign_n_reg ^ sign_d_reg) ? q_neg : quo_reg;
            Remainder <= sign_n_reg ? r_neg : rem_reg[D_WIDTH-1:0];
          end
          ready <= 1'b1;
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
          dbz   <= dz_reg;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential signed restoring divider: 16-bit dividend by 8-bit divisor, one quotient bit per clock.
- Companion/inverse of the team's sequential 8x8 signed multiplier; uses the same start/ready handshake style.
- Result semantics are Verilog-style truncating division: quotient rounds toward zero, remainder takes the dividend's sign.

Parameters:
- N_WIDTH, 16, dividend and quotient width.
- D_WIDTH, 8, divisor and remainder width (D_WIDTH <= N_WIDTH).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- Dividend  input  N_WIDTH  signed dividend; captured on the start edge.
- Divisor  input  D_WIDTH  signed divisor; captured on the start edge.
- Quotient  output  N_WIDTH  signed quotient, registered.
- Remainder  output  D_WIDTH  signed remainder, registered.
- ready  output  1  result valid.

Behaviour:
- Interface: one clock (clk); rst is asynchronous and active-high.
- Reset:
  - Quotient=0, Remainder=0, ready=0, FSM enters IDLE.
  - Counter and internal magnitudes are cleared.
  - Reset mid-division aborts immediately; no partial result is ever presented.
- States: IDLE, DIV, FIX.
- IDLE:
  - On a rising edge with start=1, capture |Dividend| (N_WIDTH unsigned) and |Divisor| (D_WIDTH unsigned).
  - Also capture the sign of the dividend, the sign of the divisor, and a zero-divisor flag.
  - Clear the partial remainder, load counter=N_WIDTH, clear ready, go to DIV.
- DIV (exactly N_WIDTH cycles):
  - Each cycle: shift {partial remainder, dividend magnitude} left by 1, then trial-subtract the divisor magnitude.
  - If the result is non-negative, keep it and set quotient bit=1; otherwise restore and set bit=0.
  - Decrement the counter; at 1 go to FIX.
  - The partial remainder is D_WIDTH+1 bits, so divisor magnitude 2^(D_WIDTH-1) (e.g. -128) is handled.
- FIX (1 cycle):
  - Negate the quotient magnitude if the operand signs differ.
  - Negate the remainder magnitude if the dividend is negative.
  - Write Quotient and Remainder, set ready=1, return to IDLE.
- Latency: ready rises on the (N_WIDTH+1)th rising edge after the capture edge, i.e. 17 cycles for the defaults. Latency is fixed and independent of operand values.
- ready:
  - Stays 1 and outputs hold until the next capture edge.
  - On that edge ready drops to 0; Quotient and Remainder hold their old values until the next FIX.
- start while in DIV/FIX is ignored. Operand inputs are don't-care after the capture edge.
- Divide by zero:
  - Full latency still applies.
  - FIX writes Quotient = max positive (16'h7FFF) if the dividend is >= 0, else min negative (16'h8000).
  - Remainder = 0.
- Overflow: -2^(N_WIDTH-1) / -1 wraps to Quotient=16'h8000, Remainder=0. No error indication.
- Width rules:
  - The absolute value of the most-negative dividend is taken as an unsigned N_WIDTH value (16'h8000 = 32768).
  - Final negation is two's complement, truncated to the port width.

Optional Feature:
- Macro: SEQ_DIVIDER_DBZ_FLAG_EN.
- Defined:
  - Adds output port dbz (1 bit), reset to 0.
  - dbz is written in FIX together with ready: 1 if the captured divisor was zero, else 0.
  - dbz holds alongside Quotient and Remainder.
- Undefined: the port is absent. Divide-by-zero saturation behaviour is identical in both builds.

Test Plan:
- Dividend=1000, Divisor=7, pulse start one cycle -> ready=1 exactly 17 cycles after the capture edge; Quotient=142, Remainder=6.
- Signed cases:
  - -1000/7 -> -142 r -6.
  - 1000/-7 -> -142 r 6.
  - -1000/-7 -> 142 r -6.
  - -128/-128 -> 1 r 0.
  - 32767/-128 -> -255 r 127.
- Boundary cases:
  - -32768/-1 -> Quotient=16'h8000, Remainder=0.
  - 5/0 -> 16'h7FFF r 0.
  - -5/0 -> 16'h8000 r 0.
  - With SEQ_DIVIDER_DBZ_FLAG_EN defined: dbz=1 for both divide-by-zero cases, dbz=0 for 1000/7.
- Start 1000/7, then reassert start with 50/5 at cycle 5 -> second request ignored; result 142 r 6 at cycle 17; ready stays 1 afterward.
- Start 1000/7, assert rst at cycle 8 (asynchronously, mid-cycle) -> outputs 0 and ready=0 immediately. After release, start 100/9 -> 11 r 1 with full 17-cycle latency.
- 100 random operand pairs back-to-back, start issued the cycle after ready -> all results match Verilog / and %, excluding the zero-divisor and overflow cases defined above.
